// File: rtl/ctrl_calendario.sv
// Calendar sequencer for the RTC date path: advances day/month/year on a daily
// tick with per-month limits (leap February) and handles Inc/Dec field editing.
module ctrl_calendario #(
    parameter int ANIO_W = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Tick_dia,
    input  logic              Modo_prog,
    input  logic [1:0]        Sel_campo,
    input  logic              Inc,
    input  logic              Dec,
    output logic [4:0]        Dia,
    output logic [3:0]        Mes,
    output logic [ANIO_W-1:0] Anio,
    output logic              Fin_mes,
    output logic              Fin_anio,
    output logic              Ocupado
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AVANZA = 2'd1,
        AJUSTA = 2'd2
    } estado_t;

    localparam logic [ANIO_W-1:0] ANIO_MAX = ANIO_W'(99);

    estado_t           state_q, state_d;
    logic [4:0]        dia_q, dia_d;
    logic [3:0]        mes_q, mes_d;
    logic [ANIO_W-1:0] anio_q, anio_d;
    logic              fin_mes_q, fin_mes_d;
    logic              fin_anio_q, fin_anio_d;
    logic              ocupado_q, ocupado_d;
    logic [4:0]        dm;

    function automatic logic [4:0] dias_mes(input logic [3:0] m, input logic [ANIO_W-1:0] a);
        if (m == 4'd1)
            return (a[1:0] == 2'b00) ? 5'd29 : 5'd28;
        else if (m == 4'd3 || m == 4'd5 || m == 4'd8 || m == 4'd10)
            return 5'd30;
        else
            return 5'd31;
    endfunction

    always_comb begin
        state_d    = state_q;
        dia_d      = dia_q;
        mes_d      = mes_q;
        anio_d     = anio_q;
        fin_mes_d  = 1'b0;
        fin_anio_d = 1'b0;
        dm         = dias_mes(mes_q, anio_q);

        unique case (state_q)
            IDLE: begin
                // Edits only in programming mode; ticks only outside it.
                if (Modo_prog) begin
                    if (Inc ^ Dec) begin
                        case (Sel_campo)
                            2'd0: begin
                                if (Inc) dia_d = (dia_q >= dm) ? 5'd1 : dia_q + 5'd1;
                                else     dia_d = (dia_q <= 5'd1) ? dm : dia_q - 5'd1;
                            end
                            2'd1: begin
                                if (Inc) mes_d = (mes_q >= 4'd11) ? 4'd0 : mes_q + 4'd1;
                                else     mes_d = (mes_q == 4'd0) ? 4'd11 : mes_q - 4'd1;
                                state_d = AJUSTA;
                            end
                            2'd2: begin
                                if (Inc) anio_d = (anio_q >= ANIO_MAX) ? '0 : anio_q + 1'b1;
                                else     anio_d = (anio_q == '0) ? ANIO_MAX : anio_q - 1'b1;
                                state_d = AJUSTA;
                            end
                            default: ;
                        endcase
                    end
                end else if (Tick_dia) begin
                    state_d = AVANZA;
                end
            end
            AVANZA: begin
                if (dia_q < dm) begin
                    dia_d = dia_q + 5'd1;
                end else begin
                    dia_d     = 5'd1;
                    fin_mes_d = 1'b1;
                    if (mes_q >= 4'd11) begin
                        mes_d      = 4'd0;
                        anio_d     = (anio_q >= ANIO_MAX) ? '0 : anio_q + 1'b1;
                        fin_anio_d = 1'b1;
                    end else begin
                        mes_d = mes_q + 4'd1;
                    end
                end
                state_d = IDLE;
            end
            AJUSTA: begin
                if (dia_q > dm) dia_d = dm;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            dia_q      <= 5'd1;
            mes_q      <= 4'd0;
            anio_q     <= '0;
            fin_mes_q  <= 1'b0;
            fin_anio_q <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dia_q      <= dia_d;
            mes_q      <= mes_d;
            anio_q     <= anio_d;
            fin_mes_q  <= fin_mes_d;
            fin_anio_q <= fin_anio_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign Dia      = dia_q;
    assign Mes      = mes_q;
    assign Anio     = anio_q;
    assign Fin_mes  = fin_mes_q;
    assign Fin_anio = fin_anio_q;
    assign Ocupado  = ocupado_q;

endmodule

// File: tb/tb_ctrl_calendario.sv
// Directed bench for ctrl_calendario: daily advance, rollovers, leap February,
// edit wrap/clamp, ignore rules and reset during an advance.
module tb_ctrl_calendario;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Tick_dia = 1'b0;
    logic       Modo_prog = 1'b0;
    logic [1:0] Sel_campo = 2'd3;
    logic       Inc = 1'b0;
    logic       Dec = 1'b0;
    logic [4:0] Dia;
    logic [3:0] Mes;
    logic [6:0] Anio;
    logic       Fin_mes;
    logic       Fin_anio;
    logic       Ocupado;

    int vectors = 0;
    int miscompares = 0;

    // Per-tick observations over the 4 cycles following the tick edge
    int ocnt, fmcnt, facnt, bothcnt;
    // Per-edit observations after edge k and k+1
    int k1_dia, k1_mes, k1_ocup, k2_dia, k2_ocup;

    ctrl_calendario #(.ANIO_W(7)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Tick_dia  (Tick_dia),
        .Modo_prog (Modo_prog),
        .Sel_campo (Sel_campo),
        .Inc       (Inc),
        .Dec       (Dec),
        .Dia       (Dia),
        .Mes       (Mes),
        .Anio      (Anio),
        .Fin_mes   (Fin_mes),
        .Fin_anio  (Fin_anio),
        .Ocupado   (Ocupado)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic do_tick(input logic modo, input logic rst_mid);
        @(negedge Clock);
        Tick_dia  = 1'b1;
        Modo_prog = modo;
        @(posedge Clock);
        #1;
        Tick_dia = 1'b0;
        if (rst_mid) Reset = 1'b1;
        ocnt    = int'(Ocupado);
        fmcnt   = int'(Fin_mes);
        facnt   = int'(Fin_anio);
        bothcnt = int'(Fin_mes & Fin_anio);
        repeat (3) begin
            @(posedge Clock);
            #1;
            Reset = 1'b0;
            ocnt    += int'(Ocupado);
            fmcnt   += int'(Fin_mes);
            facnt   += int'(Fin_anio);
            bothcnt += int'(Fin_mes & Fin_anio);
        end
    endtask

    task automatic edit(input logic [1:0] sel, input logic inc, input logic dec, input logic modo);
        @(negedge Clock);
        Modo_prog = modo;
        Sel_campo = sel;
        Inc       = inc;
        Dec       = dec;
        @(posedge Clock);
        #1;
        Inc = 1'b0;
        Dec = 1'b0;
        k1_dia  = int'(Dia);
        k1_mes  = int'(Mes);
        k1_ocup = int'(Ocupado);
        @(posedge Clock);
        #1;
        k2_dia  = int'(Dia);
        k2_ocup = int'(Ocupado);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        // Reset state
        apply_reset();
        chk("rst_dia", int'(Dia), 1);
        chk("rst_mes", int'(Mes), 0);
        chk("rst_anio", int'(Anio), 0);
        chk("rst_fin_mes", int'(Fin_mes), 0);
        chk("rst_fin_anio", int'(Fin_anio), 0);
        chk("rst_ocupado", int'(Ocupado), 0);

        // 31 daily ticks through January
        for (int i = 1; i <= 30; i++) begin
            do_tick(1'b0, 1'b0);
            chk($sformatf("ene_dia_t%0d", i), int'(Dia), i + 1);
            chk($sformatf("ene_ocup_t%0d", i), ocnt, 1);
            chk($sformatf("ene_fin_t%0d", i), fmcnt, 0);
        end
        do_tick(1'b0, 1'b0);
        chk("ene31_dia", int'(Dia), 1);
        chk("ene31_mes", int'(Mes), 1);
        chk("ene31_fin_mes", fmcnt, 1);
        chk("ene31_fin_anio", facnt, 0);
        chk("ene31_ocup", ocnt, 1);

        // Year rollover from 31/11/99
        apply_reset();
        edit(2'd2, 1'b0, 1'b1, 1'b1);
        chk("set_anio99", int'(Anio), 99);
        edit(2'd1, 1'b0, 1'b1, 1'b1);
        chk("set_mes11", int'(Mes), 11);
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        chk("set_dia31", int'(Dia), 31);
        do_tick(1'b0, 1'b0);
        chk("rollover_dia", int'(Dia), 1);
        chk("rollover_mes", int'(Mes), 0);
        chk("rollover_anio", int'(Anio), 0);
        chk("rollover_fin_mes", fmcnt, 1);
        chk("rollover_fin_anio", facnt, 1);
        chk("rollover_fin_both", bothcnt, 1);

        // Leap February (Anio = 4)
        repeat (4) edit(2'd2, 1'b1, 1'b0, 1'b1);
        edit(2'd1, 1'b1, 1'b0, 1'b1);
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        chk("feb4_dec_wrap", int'(Dia), 29);
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        chk("feb4_dia28", int'(Dia), 28);
        chk("feb4_anio", int'(Anio), 4);
        do_tick(1'b0, 1'b0);
        chk("feb4_tick_dia", int'(Dia), 29);
        chk("feb4_tick_mes", int'(Mes), 1);
        chk("feb4_tick_fin", fmcnt, 0);

        // Common February (Anio = 5)
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        edit(2'd2, 1'b1, 1'b0, 1'b1);
        chk("feb5_anio", int'(Anio), 5);
        chk("feb5_dia", int'(Dia), 28);
        do_tick(1'b0, 1'b0);
        chk("feb5_tick_dia", int'(Dia), 1);
        chk("feb5_tick_mes", int'(Mes), 2);
        chk("feb5_tick_fin", fmcnt, 1);

        // Clamp after month edit, Anio = 1
        apply_reset();
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        edit(2'd2, 1'b1, 1'b0, 1'b1);
        chk("clamp1_pre_dia", int'(Dia), 31);
        edit(2'd1, 1'b1, 1'b0, 1'b1);
        chk("clamp1_k_mes", k1_mes, 1);
        chk("clamp1_k_dia", k1_dia, 31);
        chk("clamp1_k_ocup", k1_ocup, 1);
        chk("clamp1_k1_dia", k2_dia, 28);
        chk("clamp1_k1_ocup", k2_ocup, 0);

        // Clamp after month edit, Anio = 0
        apply_reset();
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        edit(2'd1, 1'b1, 1'b0, 1'b1);
        chk("clamp0_k1_dia", k2_dia, 29);
        chk("clamp0_mes", int'(Mes), 1);

        // Month wrap and ignore rules
        apply_reset();
        edit(2'd1, 1'b0, 1'b1, 1'b1);
        chk("mes_dec_wrap", int'(Mes), 11);
        edit(2'd1, 1'b1, 1'b1, 1'b1);
        chk("incdec_mes", int'(Mes), 11);
        chk("incdec_ocup", k1_ocup, 0);
        do_tick(1'b1, 1'b0);
        chk("tick_prog_dia", int'(Dia), 1);
        chk("tick_prog_ocup", ocnt, 0);
        edit(2'd0, 1'b1, 1'b0, 1'b0);
        chk("inc_noprog_dia", int'(Dia), 1);
        edit(2'd0, 1'b1, 1'b0, 1'b1);
        chk("day_edit_dia", k1_dia, 2);
        chk("day_edit_ocup", k1_ocup, 0);

        // Reset during AVANZA from 31/11/0
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        edit(2'd0, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_dia", int'(Dia), 31);
        do_tick(1'b0, 1'b1);
        chk("rstmid_dia", int'(Dia), 1);
        chk("rstmid_mes", int'(Mes), 0);
        chk("rstmid_anio", int'(Anio), 0);
        chk("rstmid_fin_mes", fmcnt, 0);
        chk("rstmid_fin_anio", facnt, 0);
        chk("rstmid_ocup", ocnt, 1);
        chk("rstmid_idle", int'(Ocupado), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_calendario.md
# ctrl_calendario

Calendar sequencer for the RTC date path. It advances day/month/year on a one-per-day tick and applies per-month day limits, including leap-year February. It also handles Inc/Dec editing of the selected field in programming mode. `Mes` is the 0..11 month index that drives the `Ref` input of the month decoder (`Deco_Mes`). `Dia` and `Anio` feed the day and year display decoders.

## Interface
Parameters:
- `ANIO_W`, default 7: width of the year counter; year range is 0..99 (2000–2099).

Ports:
- `Clock`, in, 1: system clock; all state changes on the rising edge.
- `Reset`, in, 1: reset is synchronous and active-high; dominates all other inputs.
- `Tick_dia`, in, 1: one-cycle pulse; advance date by one day.
- `Modo_prog`, in, 1: 1 = edit mode; `Tick_dia` ignored while high.
- `Sel_campo`, in, 2: field to edit. 0 = day, 1 = month, 2 = year, 3 = none.
- `Inc`, in, 1: one-cycle pulse; increment the selected field.
- `Dec`, in, 1: one-cycle pulse; decrement the selected field.
- `Dia`, out, 5: day of month, 1..31.
- `Mes`, out, 4: month index, 0..11 (0 = January); goes to the month decoder `Ref`.
- `Anio`, out, `ANIO_W`: year offset, 0..99.
- `Fin_mes`, out, 1: one-cycle pulse when a tick rolls the month.
- `Fin_anio`, out, 1: one-cycle pulse when a tick rolls the year.
- `Ocupado`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: waits for a tick or an edit pulse.
  - AVANZA: applies one day of advance.
  - AJUSTA: clamps `Dia` after a month or year edit.
- Days in month, `dm(Mes, Anio)`:
  - `Mes` = 1: 29 if `Anio[1:0]` == 0, else 28.
  - `Mes` in {3, 5, 8, 10}: 30.
  - All other months: 31.
- Day advance (AVANZA):
  - If `Dia` < dm: `Dia` += 1.
  - Else `Dia` = 1 and `Mes` += 1, with `Fin_mes` = 1.
  - If `Mes` was 11: `Mes` = 0 and `Anio` += 1 mod 100, with `Fin_anio` = 1 as well.
- Edits, accepted only in IDLE with `Modo_prog` = 1 and exactly one of `Inc`/`Dec` high:
  - Day: wraps within 1..dm(current `Mes`, `Anio`); Inc at dm → 1, Dec at 1 → dm.
  - Month: wraps 0..11; Inc at 11 → 0, Dec at 0 → 11.
  - Year: wraps 0..99; Inc at 99 → 0, Dec at 0 → 99.
  - `Sel_campo` = 3: no change.
  - After a month or year edit, the FSM goes to AJUSTA: if `Dia` > dm(new values), `Dia` = dm.
  - Edits never assert `Fin_mes` or `Fin_anio`.
- Ignored inputs:
  - `Inc` and `Dec` both high: ignored.
  - Inc/Dec with `Modo_prog` = 0: ignored.
  - `Tick_dia` with `Modo_prog` = 1: ignored.
  - Any `Tick_dia`, `Inc` or `Dec` while not in IDLE: dropped, not queued.
- `Modo_prog` rising while in AVANZA: the advance completes normally.

## Timing
- Reset values: `Dia` = 1, `Mes` = 0, `Anio` = 0, `Fin_mes` = 0, `Fin_anio` = 0, `Ocupado` = 0, state = IDLE.
- Reset asserted in any state: state returns to IDLE on the next edge and all outputs take their reset values.
- Tick path:
  - `Tick_dia` sampled at edge k (in IDLE): state = AVANZA and `Ocupado` = 1 after edge k.
  - Edge k+1: `Dia`/`Mes`/`Anio` updated; the Fin pulses are high for exactly the cycle after edge k+1; state = IDLE; `Ocupado` = 0.
  - Latency from tick to new date: 2 edges.
  - Back-to-back ticks: the minimum accepted spacing is 2 cycles.
- Edit path:
  - Inc/Dec sampled at edge k (in IDLE): the field is updated at edge k.
  - Month/year edit: AJUSTA for one cycle; clamp applied at edge k+1; `Ocupado` is high during that cycle.
  - Day edit, or `Sel_campo` = 3: stays in IDLE; `Ocupado` stays low.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then 31 ticks spaced 4 cycles apart:
  - Ticks 1–30: `Dia` steps 2..31.
  - Tick 31: `Dia` = 1, `Mes` = 1, one `Fin_mes` pulse; `Ocupado` is high exactly 1 cycle per tick.
- Year rollover: edit to 31/11/99 (`Mes` = 11), then one tick → `Dia` = 1, `Mes` = 0, `Anio` = 0; `Fin_mes` and `Fin_anio` both pulse in the same cycle.
- February:
  - `Anio` = 4, `Mes` = 1, `Dia` = 28, one tick → `Dia` = 29.
  - `Anio` = 5, same date, one tick → `Dia` = 1, `Mes` = 2.
- Clamp:
  - `Dia` = 31, `Mes` = 0, Inc on month → `Mes` = 1, `Dia` = 28 (`Anio` = 1) one edge later.
  - Repeat with `Anio` = 0 → `Dia` = 29.
- Wrap and ignore rules:
  - Dec on month at 0 → 11.
  - Inc and Dec together → no change.
  - Tick with `Modo_prog` = 1 → no change.
  - Inc with `Modo_prog` = 0 → no change.
- Reset mid-operation: assert `Reset` in the AVANZA cycle → next edge gives 1/0/0, state IDLE, no Fin pulse.
